// File: rtl/fetch_unit.sv
// Instruction fetch stage: synchronous-read IMEM interface, output register plus one-entry skid buffer.
// Optional performance counters (fetch_count, stall_count) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] read_address,
   input  logic [31:0] instruction,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   input  logic        out_ready,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

   function automatic logic [31:0] nextAddr(input logic [31:0] pc);
      return (pc == LAST_PC) ? 32'd0 : pc + 32'd4;
   endfunction

   logic [31:0] r_fetchPc;
   logic        r_reqValid;
   logic [31:0] r_reqPc;

   logic        r_outValid;
   logic [31:0] r_outInstr;
   logic [31:0] r_outPc;
   logic [31:0] r_outPlus4;

   logic        r_skidValid;
   logic [31:0] r_skidInstr;
   logic [31:0] r_skidPc;
   logic [31:0] r_skidPlus4;

   logic        w_transfer;
   logic        w_outFree;
   logic [31:0] w_rspPlus4;
   logic [31:0] w_targetAligned;
   logic        w_issue;

   logic        w_outValidNext;
   logic [31:0] w_outInstrNext;
   logic [31:0] w_outPcNext;
   logic [31:0] w_outPlus4Next;
   logic        w_skidValidNext;
   logic [31:0] w_skidInstrNext;
   logic [31:0] w_skidPcNext;
   logic [31:0] w_skidPlus4Next;

   assign read_address    = r_fetchPc;
   assign if_valid        = r_outValid;
   assign if_instruction  = r_outInstr;
   assign if_pc           = r_outPc;
   assign if_pc_plus4     = r_outPlus4;

   assign w_transfer      = r_outValid && out_ready;
   assign w_outFree       = !r_outValid || out_ready;
   assign w_rspPlus4      = nextAddr(r_reqPc);
   assign w_targetAligned = redirect_target & 32'hFFFF_FFFC;

   // Older skid entry always drains into the output register before the in-flight response.
   always_comb begin
      w_outValidNext  = r_outValid;
      w_outInstrNext  = r_outInstr;
      w_outPcNext     = r_outPc;
      w_outPlus4Next  = r_outPlus4;
      w_skidValidNext = r_skidValid;
      w_skidInstrNext = r_skidInstr;
      w_skidPcNext    = r_skidPc;
      w_skidPlus4Next = r_skidPlus4;
      if (w_outFree) begin
         if (r_skidValid) begin
            w_outValidNext  = 1'b1;
            w_outInstrNext  = r_skidInstr;
            w_outPcNext     = r_skidPc;
            w_outPlus4Next  = r_skidPlus4;
            w_skidValidNext = r_reqValid;
            w_skidInstrNext = instruction;
            w_skidPcNext    = r_reqPc;
            w_skidPlus4Next = w_rspPlus4;
         end else begin
            w_outValidNext = r_reqValid;
            if (r_reqValid) begin
               w_outInstrNext = instruction;
               w_outPcNext    = r_reqPc;
               w_outPlus4Next = w_rspPlus4;
            end
         end
      end else if (r_reqValid) begin
         w_skidValidNext = 1'b1;
         w_skidInstrNext = instruction;
         w_skidPcNext    = r_reqPc;
         w_skidPlus4Next = w_rspPlus4;
      end
      w_issue = !redirect && !(w_outValidNext && w_skidValidNext);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchPc   <= RESET_PC;
         r_reqValid  <= 1'b0;
         r_reqPc     <= 32'd0;
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
      end else if (redirect) begin
         r_fetchPc   <= w_targetAligned;
         r_reqValid  <= 1'b0;
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
      end else begin
         r_outValid  <= w_outValidNext;
         r_skidValid <= w_skidValidNext;
         r_reqValid  <= w_issue;
         if (w_issue) begin
            r_reqPc   <= r_fetchPc;
            r_fetchPc <= nextAddr(r_fetchPc);
         end
      end
   end

   // Payload registers follow the valid bits; a flush only needs to drop the valids.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_outInstr  <= 32'd0;
         r_outPc     <= 32'd0;
         r_outPlus4  <= 32'd0;
         r_skidInstr <= 32'd0;
         r_skidPc    <= 32'd0;
         r_skidPlus4 <= 32'd0;
      end else begin
         r_outInstr  <= w_outInstrNext;
         r_outPc     <= w_outPcNext;
         r_outPlus4  <= w_outPlus4Next;
         r_skidInstr <= w_skidInstrNext;
         r_skidPc    <= w_skidPcNext;
         r_skidPlus4 <= w_skidPlus4Next;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetchCount;
   logic [31:0] r_stallCount;

   assign fetch_count = r_fetchCount;
   assign stall_count = r_stallCount;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchCount <= 32'd0;
         r_stallCount <= 32'd0;
      end else begin
         if (w_transfer) r_fetchCount <= r_fetchCount + 32'd1;
         if (r_outValid && !out_ready) r_stallCount <= r_stallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit: a program-order address model feeds an expected queue,
// and a negedge monitor pops and compares on every transfer. Define FETCH_PERF_CNT_EN to check counters.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] read_address;
   logic [31:0] instruction;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        if_valid;
   logic        out_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(256)) dut (
      .clk             (clk),
      .reset           (reset),
      .read_address    (read_address),
      .instruction     (instruction),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .out_ready       (out_ready),
      .if_instruction  (if_instruction),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
`endif
   );

   // Synchronous-read instruction memory, 64 words.
   logic [31:0] mem [64];
   always @(posedge clk) instruction <= mem[read_address[7:2]];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] plus4;
   } exp_t;

   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          transfers = 0;
   int          tbFetch = 0;
   int          tbStall = 0;
   logic [31:0] modelPc = 32'd0;
   logic        monEnable = 1'b0;

   function automatic logic [31:0] wrapAdd4(input logic [31:0] pc);
      return (pc + 32'd4) % 32'd256;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic topUp();
      exp_t e;
      while (expQ.size() < 8) begin
         e.pc    = modelPc;
         e.instr = mem[modelPc[7:2]];
         e.plus4 = wrapAdd4(modelPc);
         expQ.push_back(e);
         modelPc = wrapAdd4(modelPc);
      end
   endtask

   task automatic restart(input logic [31:0] start);
      expQ.delete();
      modelPc = (start & 32'hFFFF_FFFC) % 32'd256;
      topUp();
   endtask

   // Drives one cycle of inputs, then advances to just after the edge that consumes them.
   task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
      out_ready       = rdy;
      redirect        = redir;
      redirect_target = tgt;
      @(posedge clk);
      #1;
      if (redir && !reset) restart(tgt);
      topUp();
   endtask

   // Monitor: inputs seen at negedge are the ones the next rising edge will act on.
   logic        holdPrev = 1'b0;
   logic [31:0] hPc, hInstr, hPlus4;
   always @(negedge clk) begin
      exp_t e;
      if (reset || !monEnable) begin
         holdPrev = 1'b0;
      end else begin
         if (holdPrev) begin
            checkOutput("hold_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("hold_pc", if_pc, hPc);
            checkOutput("hold_instr", if_instruction, hInstr);
            checkOutput("hold_plus4", if_pc_plus4, hPlus4);
         end
         if (if_valid && out_ready) begin
            transfers++;
            tbFetch++;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard_empty: transfer of pc=%h with nothing expected", if_pc);
            end else begin
               e = expQ.pop_front();
               checkOutput("sb_pc", if_pc, e.pc);
               checkOutput("sb_instr", if_instruction, e.instr);
               checkOutput("sb_plus4", if_pc_plus4, e.plus4);
            end
         end
         if (if_valid && !out_ready) tbStall++;
         holdPrev = if_valid && !out_ready && !redirect;
         hPc      = if_pc;
         hInstr   = if_instruction;
         hPlus4   = if_pc_plus4;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   logic [31:0] heldAddr;
   int          guard;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      reset           = 1'b0;
      out_ready       = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'd0;
      #1 reset = 1'b1;

      // Reset state, with a redirect that must be ignored.
      redirect        = 1'b1;
      redirect_target = 32'h0000_0080;
      #12;
      checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("rst_instr", if_instruction, 32'd0);
      checkOutput("rst_pc", if_pc, 32'd0);
      checkOutput("rst_plus4", if_pc_plus4, 32'd0);
      checkOutput("rst_raddr", read_address, RESET_PC);
      @(posedge clk);
      #1;
      checkOutput("rst_redirect_ignored", read_address, RESET_PC);

      // Release and stream with out_ready high: first valid on the second edge, then no bubbles.
      reset    = 1'b0;
      redirect = 1'b0;
      restart(RESET_PC);
      monEnable = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("first_edge_invalid", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("first_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("first_pc", if_pc, RESET_PC);
      for (int i = 0; i < 70; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("no_bubble", {31'd0, if_valid}, 32'd1);
      end

      // Five stalled cycles: outputs held, fetch address frozen once skid fills.
      applyStimulus(1'b0, 1'b0, 32'd0);
      heldAddr = read_address;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("stall_no_issue", read_address, heldAddr);
      checkOutput("stall_valid", {31'd0, if_valid}, 32'd1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0);

      // Redirect to an unaligned target.
      applyStimulus(1'b1, 1'b1, 32'h0000_0042);
      checkOutput("redir_gap1", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("redir_gap2", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("redir_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("redir_pc", if_pc, 32'h0000_0040);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("redir_next_pc", if_pc, 32'h0000_0044);

      // Wrap at the top of the memory.
      applyStimulus(1'b1, 1'b1, 32'h0000_00F8);
      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("wrap_pc_f8", if_pc, 32'h0000_00F8);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("wrap_pc_fc", if_pc, 32'h0000_00FC);
      checkOutput("wrap_plus4_fc", if_pc_plus4, 32'h0000_0000);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("wrap_pc_00", if_pc, 32'h0000_0000);

      // Back-to-back redirects: only the last target is fetched.
      applyStimulus(1'b1, 1'b1, 32'h0000_0010);
      applyStimulus(1'b1, 1'b1, 32'h0000_0080);
      checkOutput("dbl_gap1", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("dbl_gap2", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("dbl_pc", if_pc, 32'h0000_0080);

      // Transfer coinciding with redirect, then asynchronous reset mid-cycle.
      applyStimulus(1'b1, 1'b1, 32'h0000_0020);
      guard = 0;
      while (!if_valid && guard < 10) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("pre_reset_valid", {31'd0, if_valid}, 32'd1);
      @(negedge clk);
      #2;
      reset   = 1'b1;
      tbFetch = 0;
      tbStall = 0;
      #1;
      checkOutput("async_rst_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("async_rst_pc", if_pc, 32'd0);
      checkOutput("async_rst_raddr", read_address, RESET_PC);
      redirect        = 1'b1;
      redirect_target = 32'h0000_0060;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      redirect = 1'b0;
      restart(RESET_PC);
      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("restart_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("restart_pc", if_pc, RESET_PC);

      // Randomized backpressure and redirects.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 255));
      end
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("progress", {31'd0, transfers > 800}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
      checkOutput("fetch_count", fetch_count, tbFetch);
      checkOutput("stall_count", stall_count, tbStall);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
